// File: rtl/cpu_clk_ctrl.sv
// ============================================================================
// Module : cpu_clk_ctrl
// Brief  : CPU clock-enable sequencer (HALT / RUN at divisor / single STEP).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_clk_ctrl #(
  parameter int          CNT_W       = 26,
  parameter int unsigned DEFAULT_DIV = 50_000_000,
  parameter int          TCNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              div_we,
  input  logic [CNT_W-1:0]  div_in,
  input  logic              run,
  input  logic              step,
  input  logic              halt_req,
  output logic              tick,
  output logic              running,
  output logic              halted,
  output logic [TCNT_W-1:0] tick_cnt
);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   div_q;
  logic               tick_q;
  logic [TCNT_W-1:0]  tick_cnt_q;
  logic               step_q;
  logic               hlt_flag_q;

  logic               step_edge;
  logic [CNT_W-1:0]   last_cnt;
  logic               period_done;

  assign step_edge   = step & ~step_q;
  // Divisors of 0 and 1 both mean "tick every cycle", so the terminal count is 0.
  assign last_cnt    = (div_q < CNT_W'(2)) ? '0 : (div_q - CNT_W'(1));
  assign period_done = (cnt_q == last_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_HALT;
      cnt_q      <= '0;
      div_q      <= CNT_W'(DEFAULT_DIV);
      tick_q     <= 1'b0;
      tick_cnt_q <= '0;
      step_q     <= 1'b0;
      hlt_flag_q <= 1'b0;
    end else begin
      step_q <= step;
      tick_q <= 1'b0;

      // Latched HLT blocks re-entry into RUN until the run switch is released.
      if (halt_req) begin
        hlt_flag_q <= 1'b1;
      end else if (!run) begin
        hlt_flag_q <= 1'b0;
      end

      if (halt_req) begin
        state_q <= S_HALT;
        cnt_q   <= '0;
      end else if (div_we) begin
        div_q <= div_in;
        cnt_q <= '0;
      end else begin
        case (state_q)
          S_HALT: begin
            if (run && !hlt_flag_q) begin
              state_q <= S_RUN;
              cnt_q   <= '0;
            end else if (step_edge) begin
              state_q <= S_STEP;
              cnt_q   <= '0;
            end
          end
          S_RUN: begin
            if (!run) begin
              state_q <= S_HALT;
              cnt_q   <= '0;
            end else if (period_done) begin
              tick_q     <= 1'b1;
              tick_cnt_q <= tick_cnt_q + TCNT_W'(1);
              cnt_q      <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_STEP: begin
            if (period_done) begin
              tick_q     <= 1'b1;
              tick_cnt_q <= tick_cnt_q + TCNT_W'(1);
              cnt_q      <= '0;
              state_q    <= S_HALT;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= S_HALT;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign tick     = tick_q;
  assign tick_cnt = tick_cnt_q;
  assign running  = (state_q == S_RUN);
  assign halted   = (state_q == S_HALT);

endmodule

`default_nettype wire
